// File: rtl/bus_slave_responder_pkg.sv
// Shared bus definitions for the slave responder: bus widths, Control field
// positions, FSM state encoding and the latched request record.
package bus_slave_responder_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int CTRL_W = 9;

    localparam int CTRL_VALID  = 8;
    localparam int CTRL_WRITE  = 7;
    localparam int CTRL_LEN_HI = 6;
    localparam int CTRL_LEN_LO = 4;
    localparam int CTRL_BE_HI  = 3;
    localparam int CTRL_BE_LO  = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_XFER = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // Request fields captured at accept; later Control changes are ignored.
    typedef struct packed {
        logic       write;
        logic [2:0] len;   // beats - 1
        logic [3:0] be;
    } req_t;

    // Extract the request fields from Control bits below Valid.
    function automatic req_t decode_ctrl(input logic [CTRL_WRITE:0] bits);
        req_t r;
        r.write = bits[CTRL_WRITE];
        r.len   = bits[CTRL_LEN_HI:CTRL_LEN_LO];
        r.be    = bits[CTRL_BE_HI:CTRL_BE_LO];
        return r;
    endfunction

endpackage

// File: rtl/bus_slave_responder_mem.sv
// Word memory behind the slave responder: one synchronous read port with a
// resettable, enable-held output register and one byte-enabled write port.
module bus_slave_responder_mem
    import bus_slave_responder_pkg::*;
#(
    parameter int ADDR_BITS = 8,
    parameter bit INIT_ZERO = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 we_i,
    input  logic [3:0]           be_i,
    input  logic [ADDR_BITS-1:0] waddr_i,
    input  logic [DATA_W-1:0]    wdata_i,
    input  logic                 re_i,
    input  logic [ADDR_BITS-1:0] raddr_i,
    output logic [DATA_W-1:0]    rdata_o
);

    localparam int DEPTH = 2 ** ADDR_BITS;

    logic [DATA_W-1:0] rd_word;
    logic [DATA_W-1:0] rdata_q;

    if (INIT_ZERO) begin : g_zero
        logic [DATA_W-1:0] mem_q [DEPTH] = '{default: '0};

        // Byte-lane write; only lanes with their enable set are updated.
        // NOTE: storage has no reset, so a burst cut short by reset keeps the beats it already wrote.
        always_ff @(posedge clk) begin
            if (we_i) begin
                for (int l = 0; l < 4; l++) begin
                    if (be_i[l]) mem_q[waddr_i][8*l +: 8] <= wdata_i[8*l +: 8];
                end
            end
        end

        assign rd_word = mem_q[raddr_i];
    end else begin : g_raw
        logic [DATA_W-1:0] mem_q [DEPTH];

        // Byte-lane write; only lanes with their enable set are updated.
        always_ff @(posedge clk) begin
            if (we_i) begin
                for (int l = 0; l < 4; l++) begin
                    if (be_i[l]) mem_q[waddr_i][8*l +: 8] <= wdata_i[8*l +: 8];
                end
            end
        end

        assign rd_word = mem_q[raddr_i];
    end

    // Read register: loads only on a read fetch, otherwise holds the last word read.
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    rdata_q <= '0;
        else if (re_i) rdata_q <= rd_word;
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/bus_slave_responder.sv
// Slave-side bus responder: accepts a request from the winning master, waits a
// fixed number of cycles, then serves a 1-8 beat burst with one Ready per beat.
module bus_slave_responder
    import bus_slave_responder_pkg::*;
#(
    parameter int ADDR_BITS   = 8,
    parameter int WAIT_STATES = 2,
    parameter int INIT_ZERO   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic [ADDR_W-1:0] Address,
    input  logic [CTRL_W-1:0] Control,
    input  logic [DATA_W-1:0] DataIn,
    output logic [DATA_W-1:0] DataOut,
    output logic              Ready
);

    // Last wait count before the first beat; unused when WAIT_STATES is 0.
    localparam logic [3:0] WAIT_LAST = 4'(WAIT_STATES - 1);

    state_e                state_q, state_d;
    logic [3:0]            wait_q,  wait_d;
    logic [2:0]            beat_q,  beat_d;
    logic [ADDR_BITS-1:0]  idx_q,   idx_d;
    req_t                  req_q,   req_d;

    logic ready;
    logic mem_we;
    logic mem_re;

    // Address decode is done upstream; only the word index bits matter here.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{Address[ADDR_W-1:ADDR_BITS+2], Address[1:0]};

    // State and burst bookkeeping registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            wait_q  <= '0;
            beat_q  <= '0;
            idx_q   <= '0;
            req_q   <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            beat_q  <= beat_d;
            idx_q   <= idx_d;
            req_q   <= req_d;
        end
    end

    // Next-state: accept, wait-state count, beat sequencing, abort and re-arm.
    // NOTE: every output gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        beat_d  = beat_q;
        idx_d   = idx_q;
        req_d   = req_q;
        unique case (state_q)
            ST_IDLE: begin
                if (en && Control[CTRL_VALID]) begin
                    req_d   = decode_ctrl(Control[CTRL_WRITE:0]);
                    idx_d   = Address[ADDR_BITS+1:2];
                    wait_d  = '0;
                    beat_d  = '0;
                    state_d = (WAIT_STATES == 0) ? ST_XFER : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!en)                    state_d = ST_IDLE;
                else if (wait_q == WAIT_LAST) state_d = ST_XFER;
                else                        wait_d  = wait_q + 4'd1;
            end
            ST_XFER: begin
                // The current beat always completes; en only decides where we go next.
                beat_d = beat_q + 3'd1;
                idx_d  = idx_q + ADDR_BITS'(1);
                if (!en)                        state_d = ST_IDLE;
                else if (beat_q == req_q.len)   state_d = ST_DONE;
            end
            ST_DONE: begin
                // Wait for the master to release Valid so a held request is not served twice.
                if (!en || !Control[CTRL_VALID]) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs: Ready and the write strobe for every transfer cycle.
    always_comb begin
        ready  = 1'b0;
        mem_we = 1'b0;
        if (state_q == ST_XFER) begin
            ready  = 1'b1;
            mem_we = req_q.write;
        end
    end

    // Fetch read data one cycle ahead so it sits in the output register during Ready.
    assign mem_re = (state_d == ST_XFER) && !req_d.write;
    assign Ready  = ready;

    bus_slave_responder_mem #(
        .ADDR_BITS (ADDR_BITS),
        .INIT_ZERO (INIT_ZERO != 0)
    ) u_mem (
        .clk     (clk),
        .rst_n   (reset),
        .we_i    (mem_we),
        .be_i    (req_q.be),
        .waddr_i (idx_q),
        .wdata_i (DataIn),
        .re_i    (mem_re),
        .raddr_i (idx_d),
        .rdata_o (DataOut)
    );

endmodule
